// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner_if
//  Purpose  : Raw pad inputs and conditioned outputs of input_conditioner.
//  Revision : 1.0  initial release
// ============================================================================
interface input_conditioner_if;
    logic [7:0] sw_raw;
    logic       select_raw;
    logic [7:0] sw;
    logic       select;
    logic       select_press;
    logic       select_release;
    logic       sw_change;

    // master drives the pads and observes the clean levels; slave is the conditioner
    modport master (
        output sw_raw, select_raw,
        input  sw, select, select_press, select_release, sw_change
    );

    modport slave (
        input  sw_raw, select_raw,
        output sw, select, select_press, select_release, sw_change
    );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Synchronises and debounces slide switches and the active-low
//             button, emitting clean levels and one-cycle change pulses.
//  Revision : 1.0  initial release
// ============================================================================
module input_conditioner #(
    parameter int CLKSPEED    = 50000000,
    parameter int DEBOUNCE_MS = 10
) (
    input  wire                  clk,
    input  wire                  reset_b,
    input_conditioner_if.slave   bus
);

    localparam int              c_N        = 9;
    localparam int              c_TICK_DIV = CLKSPEED / 1000;
    localparam int              c_PW       = $clog2(c_TICK_DIV);
    localparam int              c_CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [c_PW-1:0] c_PLAST    = c_PW'(c_TICK_DIV - 1);
    localparam logic [c_CW-1:0] c_CLAST    = c_CW'(DEBOUNCE_MS - 1);
    // Bit 8 carries the raw button, whose idle level is high
    localparam logic [c_N-1:0]  c_SYNC_RST = 9'h100;

    logic [c_N-1:0]  r_sync1;
    logic [c_N-1:0]  r_sync2;
    logic [c_N-1:0]  w_synced;
    logic [c_PW-1:0] r_presc;
    logic            w_tick;
    logic [c_N-1:0]  w_stable;
    logic [c_N-1:0]  w_accept;
    logic            r_sw_change;
    logic            r_press;
    logic            r_release;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
        end else begin
            r_sync1 <= {bus.select_raw, bus.sw_raw};
            r_sync2 <= r_sync1;
        end
    end

    assign w_synced = {~r_sync2[8], r_sync2[7:0]};

    assign w_tick = (r_presc == c_PLAST);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    for (genvar gi = 0; gi < c_N; gi++) begin : g_deb
        logic [c_CW-1:0] r_cnt;
        logic            r_stable;
        logic            w_mismatch;

        assign w_mismatch   = (w_synced[gi] != r_stable);
        assign w_accept[gi] = w_mismatch && w_tick && (r_cnt == c_CLAST);
        assign w_stable[gi] = r_stable;

        // Any cycle back at the stable level discards the partial count
        always_ff @(posedge clk) begin
            if (!reset_b) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (w_accept[gi]) begin
                    r_stable <= w_synced[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
    end

    // Pulses register on the same edge as the stable level they announce
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_sw_change <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_sw_change <= |w_accept[7:0];
            r_press     <= w_accept[8] &  w_synced[8];
            r_release   <= w_accept[8] & ~w_synced[8];
        end
    end

    assign bus.sw             = w_stable[7:0];
    assign bus.select         = w_stable[8];
    assign bus.sw_change      = r_sw_change;
    assign bus.select_press   = r_press;
    assign bus.select_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_conditioner
//  Purpose  : Self-checking bench for input_conditioner (TICK_DIV=10, 3 ms).
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_conditioner;

    localparam int LAT_MIN = 23;
    localparam int LAT_MAX = 32;

    typedef enum int {EV_SW, EV_PRESS, EV_REL} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [7:0] sw;
        logic       sel;
        int         tref;
    } ev_t;

    typedef struct {
        logic [7:0] raw;
        int         hold;
        logic [7:0] back;
        logic [7:0] exp_sw;
        bit         evt;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    ev_t  sb[$];
    vec_t vecs[7];

    input_conditioner_if bus ();

    input_conditioner #(
        .CLKSPEED    (10000),
        .DEBOUNCE_MS (3)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] s, input logic sel);
        ev_t e;
        e.kind = k;
        e.sw   = s;
        e.sel  = sel;
        e.tref = cyc;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        int  dt;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got %s pulse at cycle %0d, expected none", k.name(), cyc);
            return;
        end
        e  = sb.pop_front();
        dt = cyc - e.tref;
        if (e.kind != k || dt < LAT_MIN || dt > LAT_MAX ||
            (k == EV_SW && bus.sw !== e.sw) || (k != EV_SW && bus.select !== e.sel)) begin
            failures++;
            $display("FAIL event: got %s sw=%h sel=%b dt=%0d, expected %s sw=%h sel=%b dt in [%0d,%0d]",
                     k.name(), bus.sw, bus.select, dt, e.kind.name(), e.sw, e.sel, LAT_MIN, LAT_MAX);
        end
    endtask

    // Every pulse must match the head of the expected-event queue
    initial forever begin
        @(negedge clk);
        if (bus.sw_change === 1'b1)      observe(EV_SW);
        if (bus.select_press === 1'b1)   observe(EV_PRESS);
        if (bus.select_release === 1'b1) observe(EV_REL);
    end

    initial begin
        vecs[0] = '{raw: 8'h00, hold: 40, back: 8'h00, exp_sw: 8'h00, evt: 1'b1};
        vecs[1] = '{raw: 8'h08, hold: 15, back: 8'h00, exp_sw: 8'h00, evt: 1'b0};
        vecs[2] = '{raw: 8'h08, hold: 40, back: 8'h08, exp_sw: 8'h08, evt: 1'b1};
        vecs[3] = '{raw: 8'h89, hold: 40, back: 8'h89, exp_sw: 8'h89, evt: 1'b1};
        vecs[4] = '{raw: 8'h81, hold: 19, back: 8'h89, exp_sw: 8'h89, evt: 1'b0};
        vecs[5] = '{raw: 8'hF0, hold: 40, back: 8'hF0, exp_sw: 8'hF0, evt: 1'b1};
        vecs[6] = '{raw: 8'h0F, hold: 5,  back: 8'hF0, exp_sw: 8'hF0, evt: 1'b0};

        bus.sw_raw     = 8'hFF;
        bus.select_raw = 1'b1;
        reset_b        = 1'b0;

        // Power-up: outputs held low in reset, then switches accepted once
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", {20'd0, bus.sw, bus.select, bus.select_press,
                                    bus.select_release, bus.sw_change}, 32'd0);
        end
        reset_b = 1'b1;
        expect_ev(EV_SW, 8'hFF, 1'b0);
        wait_cycles(40);
        check("powerup_sw", {24'd0, bus.sw}, 32'h00FF);
        check("powerup_select", {31'd0, bus.select}, 32'd0);
        check("powerup_drained", sb.size(), 32'd0);

        // Bouncing press followed by a clean hold
        for (int i = 0; i < 12; i++) begin
            bus.select_raw = ~bus.select_raw;
            wait_cycles(5);
        end
        bus.select_raw = 1'b0;
        expect_ev(EV_PRESS, 8'h00, 1'b1);
        wait_cycles(40);
        check("press_select", {31'd0, bus.select}, 32'd1);
        check("press_drained", sb.size(), 32'd0);

        bus.select_raw = 1'b1;
        expect_ev(EV_REL, 8'h00, 1'b0);
        wait_cycles(40);
        check("release_select", {31'd0, bus.select}, 32'd0);
        check("release_drained", sb.size(), 32'd0);

        for (int v = 0; v < 7; v++) begin
            bus.sw_raw = vecs[v].raw;
            if (vecs[v].evt) expect_ev(EV_SW, vecs[v].exp_sw, 1'b0);
            wait_cycles(vecs[v].hold);
            bus.sw_raw = vecs[v].back;
            wait_cycles(40);
            check($sformatf("vec%0d_sw", v), {24'd0, bus.sw}, {24'd0, vecs[v].exp_sw});
            check($sformatf("vec%0d_drained", v), sb.size(), 32'd0);
        end

        // Reset mid-count discards the partial accumulation
        bus.sw_raw = 8'hF2;
        wait_cycles(15);
        reset_b = 1'b0;
        wait_cycles(1);
        check("midreset_outputs", {20'd0, bus.sw, bus.select, bus.select_press,
                                   bus.select_release, bus.sw_change}, 32'd0);
        reset_b = 1'b1;
        expect_ev(EV_SW, 8'hF2, 1'b0);
        wait_cycles(40);
        check("midreset_sw", {24'd0, bus.sw}, 32'h00F2);
        check("midreset_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
